preg_reclaim: RTL and testbench
===============================

PREG_RECLAIM -- requirements
Module: preg_reclaim

Interface
REQ-001 Parameter WIDTH, default 5, physical-register index width.
REQ-002 Parameter DEPTH, default 8, reclaim buffer entries; power of two, >= 4.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  2  per-lane commit strobe: bit0 lane 0, bit1 lane 1.
REQ-006 i_preg0  input  WIDTH  old physical destination released by lane 0.
REQ-007 i_preg1  input  WIDTH  old physical destination released by lane 1.
REQ-008 o_ready  output  1  buffer can take two entries this cycle.
REQ-009 o_fl_data  output  WIDTH  index returned to freelist (drives freelist i_data).
REQ-010 o_fl_we  output  1  freelist write strobe (drives freelist i_we).
REQ-011 i_fl_full  input  1  freelist cannot accept a write this cycle.
REQ-012 o_count  output  $clog2(DEPTH)+1  entries currently buffered.

Function
REQ-013 The block SHALL hold released indices in a circular FIFO of DEPTH entries with head pointer, tail pointer and count.
REQ-014 o_ready SHALL be combinational: 1 when (DEPTH - count) >= 2.
REQ-015 Accept condition: a lane SHALL be accepted only when its i_valid bit is 1, o_ready is 1, and its index is nonzero.
- Index 0 is hardwired zero and SHALL never be enqueued.
REQ-016 Accepted entries SHALL be compacted.
- Both accepted: lane 0 goes at tail, lane 1 at tail+1; tail advances by 2.
- One accepted: it goes at tail; tail advances by 1.
REQ-017 When o_ready is 0, all i_valid bits SHALL be ignored, with no state change from the input side; the sender holds its data.
REQ-018 o_fl_we SHALL equal (count != 0) && !i_fl_full.
- o_fl_data SHALL equal the head entry combinationally.
- o_fl_data SHALL be 0 when the buffer is empty.
REQ-019 Each cycle with o_fl_we = 1 SHALL pop exactly one entry (head += 1).
REQ-020 Latency: an index accepted in cycle N SHALL be visible at o_fl_data no earlier than cycle N+1; there is no input-to-output bypass.
REQ-021 Simultaneous push and pop in one cycle: count_next = count + accepted - popped, range 0..DEPTH; both SHALL take effect.
REQ-022 Pointers SHALL wrap modulo DEPTH; wrap-around SHALL NOT alter ordering (strict FIFO).
REQ-023 While i_fl_full is 1, entries SHALL be retained unchanged and o_fl_we SHALL be 0.

Reset
REQ-024 Asserting i_rst at any time, including mid-transfer, SHALL immediately force the following; buffered indices are discarded:
- head = tail = 0, count = 0
- o_fl_we = 0, o_fl_data = 0, o_ready = 1, o_count = 0
REQ-025 The first enqueue SHALL be possible on the first rising edge after i_rst deasserts.

Structure
REQ-026 WIDTH, PREG_ZERO (index 0) and the commit-lane count (2) SHALL live in the shared core package, shared with the freelist and rename logic.
REQ-027 The two-lane zero-filter/compaction SHALL be a sub-module, reclaim_compact, outputting the push count (0..2) and two ordered entries.
REQ-028 FIFO storage SHALL be a register array with no reset on the data words; only pointers and count are reset.

Verification
REQ-029 After reset: i_valid=2'b11, preg0=5, preg1=9, i_fl_full=0 for one cycle -> o_fl_we=1 with data 5, then 9 on the next cycle; o_count returns to 0.
REQ-030 i_valid=2'b11, preg0=0, preg1=7 -> only 7 is enqueued; o_count=1; index 0 never appears on o_fl_data.
REQ-031 Hold i_fl_full=1 while pushing pairs until o_count=7 -> o_ready=0; further valid inputs are ignored; o_count stays 7.
REQ-032 Push/pop wrap-around over 3*DEPTH indices 1..24 with i_fl_full toggling at random -> the output sequence is exactly 1..24 in order.
REQ-033 Assert i_rst asynchronously with o_count=4 -> o_fl_we=0 and o_count=0 before the next clock edge; after release, a push of index 3 yields o_fl_data=3.
REQ-034 Loopback with a 31-entry freelist (WIDTH=5, freelist read each cycle, its output fed to i_preg0): no index is lost or duplicated over 1000 cycles.

Source files
------------

// File: rtl/preg_reclaim_pkg.sv
// Shared core package for the rename back end.
//
// Holds the constants that the freelist, rename logic and the reclaim buffer
// must agree on: physical-register index width, the hardwired-zero index and
// the number of commit lanes.
package preg_reclaim_pkg;

    // Physical-register index width (32 physical registers).
    localparam int unsigned PREG_WIDTH = 5;

    // Index 0 is the hardwired-zero register; it is never allocated or freed.
    localparam int unsigned PREG_ZERO = 0;

    // Number of instructions that can commit (and release a register) per cycle.
    localparam int unsigned COMMIT_LANES = 2;

    // Width of a per-cycle push count, 0..COMMIT_LANES.
    localparam int unsigned PUSH_CNT_W = $clog2(COMMIT_LANES + 1);

    // Which commit lanes carry a reclaimable (valid, nonzero) index.
    typedef enum logic [1:0] {
        LaneNone  = 2'b00,
        Lane0Only = 2'b01,
        Lane1Only = 2'b10,
        LaneBoth  = 2'b11
    } lane_sel_e;

    // True when an index names a real, reclaimable physical register.
    function automatic logic preg_is_real(input logic [PREG_WIDTH-1:0] preg);
        return preg != PREG_WIDTH'(PREG_ZERO);
    endfunction

endpackage

// File: rtl/preg_reclaim_compact.sv
// reclaim_compact: two-lane zero filter and compaction for the reclaim buffer.
//
// A lane contributes an entry only when it is valid and its index is not the
// hardwired-zero register. Surviving entries are packed toward entry 0 so the
// buffer can write them at tail and tail+1 without holes.
//
// Ports:
//   i_valid    [1:0]        per-lane commit strobe, already gated by o_ready
//   i_preg0    [WIDTH-1:0]  lane 0 released index
//   i_preg1    [WIDTH-1:0]  lane 1 released index
//   o_push_cnt [1:0]        number of entries to enqueue (0..2)
//   o_entry0   [WIDTH-1:0]  first entry in program order (valid if cnt >= 1)
//   o_entry1   [WIDTH-1:0]  second entry (valid if cnt == 2)
module reclaim_compact
    import preg_reclaim_pkg::*;
#(
    parameter int unsigned WIDTH = PREG_WIDTH
) (
    input  logic [COMMIT_LANES-1:0] i_valid,
    input  logic [WIDTH-1:0]        i_preg0,
    input  logic [WIDTH-1:0]        i_preg1,
    output logic [PUSH_CNT_W-1:0]   o_push_cnt,
    output logic [WIDTH-1:0]        o_entry0,
    output logic [WIDTH-1:0]        o_entry1
);

    logic      lane0_ok;
    logic      lane1_ok;
    lane_sel_e lane_sel;

    always_comb begin
        lane0_ok = i_valid[0] && (i_preg0 != WIDTH'(PREG_ZERO));
        lane1_ok = i_valid[1] && (i_preg1 != WIDTH'(PREG_ZERO));
        lane_sel = lane_sel_e'({lane1_ok, lane0_ok});
    end

    always_comb begin
        o_push_cnt = '0;
        o_entry0   = '0;
        o_entry1   = '0;
        unique case (lane_sel)
            LaneNone: begin
                o_push_cnt = PUSH_CNT_W'(0);
            end
            Lane0Only: begin
                o_push_cnt = PUSH_CNT_W'(1);
                o_entry0   = i_preg0;
            end
            Lane1Only: begin
                // Lane 1 alone slides down into the first slot.
                o_push_cnt = PUSH_CNT_W'(1);
                o_entry0   = i_preg1;
            end
            LaneBoth: begin
                o_push_cnt = PUSH_CNT_W'(2);
                o_entry0   = i_preg0;
                o_entry1   = i_preg1;
            end
            default: begin
                o_push_cnt = '0;
            end
        endcase
    end

endmodule

// File: rtl/preg_reclaim.sv
// preg_reclaim: buffers physical registers released at commit and trickles
// them back to the freelist one per cycle.
//
// Up to two indices arrive per cycle from the commit lanes; they are filtered
// (index 0 dropped), compacted and pushed into a circular FIFO. The head entry
// is offered to the freelist every cycle the FIFO is non-empty and the
// freelist is not full. Push and pop may happen in the same cycle.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset; discards buffered indices
//   i_valid    [1:0] per-lane commit strobe
//   i_preg0    [WIDTH-1:0] index released by lane 0
//   i_preg1    [WIDTH-1:0] index released by lane 1
//   o_ready    room for two entries this cycle; inputs ignored when low
//   o_fl_data  [WIDTH-1:0] head entry to the freelist, 0 when empty
//   o_fl_we    freelist write strobe, pops the head
//   i_fl_full  freelist cannot accept a write this cycle
//   o_count    [$clog2(DEPTH):0] entries currently buffered
module preg_reclaim
    import preg_reclaim_pkg::*;
#(
    parameter int unsigned WIDTH = PREG_WIDTH,
    // Must be a power of two, at least 4, so the pointers wrap for free.
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [COMMIT_LANES-1:0]  i_valid,
    input  logic [WIDTH-1:0]         i_preg0,
    input  logic [WIDTH-1:0]         i_preg1,
    output logic                     o_ready,
    output logic [WIDTH-1:0]         o_fl_data,
    output logic                     o_fl_we,
    input  logic                     i_fl_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                  ready;
    logic                  pop;
    logic [COMMIT_LANES-1:0] valid_gated;
    logic [PUSH_CNT_W-1:0] push_cnt;
    logic [WIDTH-1:0]      entry0;
    logic [WIDTH-1:0]      entry1;
    logic [PTR_W-1:0]      tail_plus1;

    // Room for a full pair is required even if only one lane is valid, so the
    // sender sees a single, lane-independent handshake.
    always_comb begin
        ready       = count_q <= CNT_W'(DEPTH - 2);
        pop         = (count_q != '0) && !i_fl_full;
        valid_gated = ready ? i_valid : '0;
    end

    reclaim_compact #(
        .WIDTH (WIDTH)
    ) u_compact (
        .i_valid    (valid_gated),
        .i_preg0    (i_preg0),
        .i_preg1    (i_preg1),
        .o_push_cnt (push_cnt),
        .o_entry0   (entry0),
        .o_entry1   (entry1)
    );

    always_comb begin
        tail_plus1 = tail_q + PTR_W'(1);
        head_d     = pop ? head_q + PTR_W'(1) : head_q;
        tail_d     = tail_q + PTR_W'(push_cnt);
        count_d    = count_q + CNT_W'(push_cnt) - {{(CNT_W-1){1'b0}}, pop};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Data words are not reset; count gates everything read out of them.
    always_ff @(posedge i_clk) begin
        if (push_cnt != '0) begin
            mem[tail_q] <= entry0;
        end
        if (push_cnt == PUSH_CNT_W'(2)) begin
            mem[tail_plus1] <= entry1;
        end
    end

    // Read straight from storage: a pushed entry is only visible once written.
    always_comb begin
        o_ready   = ready;
        o_fl_we   = pop;
        o_fl_data = (count_q != '0) ? mem[head_q] : '0;
        o_count   = count_q;
    end

endmodule

// File: tb/tb_preg_reclaim.sv
// Self-checking bench for preg_reclaim. A queue-based reference model tracks
// the buffered indices; every cycle the DUT outputs are compared against it.
module tb_preg_reclaim;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned DEPTH = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       valid;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] p1;
    logic             fl_full;
    logic             o_ready;
    logic [WIDTH-1:0] o_fl_data;
    logic             o_fl_we;
    logic [3:0]       o_count;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO of buffered indices.
    int unsigned q[$];

    preg_reclaim #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_preg0   (p0),
        .i_preg1   (p1),
        .o_ready   (o_ready),
        .o_fl_data (o_fl_data),
        .o_fl_we   (o_fl_we),
        .i_fl_full (fl_full),
        .o_count   (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_ready();
        return (DEPTH - q.size()) >= 2;
    endfunction

    function automatic logic m_we();
        return (q.size() != 0) && !fl_full;
    endfunction

    function automatic logic [WIDTH-1:0] m_data();
        return (q.size() != 0) ? WIDTH'(q[0]) : '0;
    endfunction

    function automatic logic [3:0] m_count();
        return 4'(q.size());
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic rdy;
        logic pp;
        @(posedge clk);
        rdy = m_ready();
        pp  = m_we();
        if (pp) void'(q.pop_front());
        if (rdy) begin
            if (valid[0] && p0 != 0) q.push_back(int'(p0));
            if (valid[1] && p1 != 0) q.push_back(int'(p1));
        end
        #1;
    endtask

    task automatic do_reset();
        valid   = 2'b00;
        fl_full = 1'b0;
        rst     = 1'b1;
        #2;
        rst     = 1'b0;
        q.delete();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 2'b11; p0 = 5'd3; p1 = 5'd4; fl_full = 1'b0;
        #1;
        checks += 4;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        if (o_fl_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", o_fl_we); end
        if (o_fl_data !== 5'd0) begin errors++; $display("FAIL reset_data got=%0d want=0", o_fl_data); end
        if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", o_count); end
        valid = 2'b00;
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_pair();
        valid = 2'b11; p0 = 5'd5; p1 = 5'd9; fl_full = 1'b0;
        #1;
        checks += 2;
        if (o_fl_we !== 1'b0) begin errors++; $display("FAIL pair_nobypass_we got=%b want=0", o_fl_we); end
        if (o_count !== 4'd0) begin errors++; $display("FAIL pair_pre_count got=%0d want=0", o_count); end
        tick();
        valid = 2'b00;
        #1;
        checks += 3;
        if (o_fl_we !== 1'b1) begin errors++; $display("FAIL pair_we1 got=%b want=1", o_fl_we); end
        if (o_fl_data !== 5'd5) begin errors++; $display("FAIL pair_data1 got=%0d want=5", o_fl_data); end
        if (o_count !== 4'd2) begin errors++; $display("FAIL pair_count1 got=%0d want=2", o_count); end
        tick();
        checks += 2;
        if (o_fl_data !== 5'd9) begin errors++; $display("FAIL pair_data2 got=%0d want=9", o_fl_data); end
        if (o_fl_we !== 1'b1) begin errors++; $display("FAIL pair_we2 got=%b want=1", o_fl_we); end
        tick();
        checks += 2;
        if (o_count !== 4'd0) begin errors++; $display("FAIL pair_count_end got=%0d want=0", o_count); end
        if (o_fl_we !== 1'b0) begin errors++; $display("FAIL pair_we_end got=%b want=0", o_fl_we); end
    endtask

    task automatic test_zero_filter();
        valid = 2'b11; p0 = 5'd0; p1 = 5'd7; fl_full = 1'b1;
        tick();
        valid = 2'b00;
        #1;
        checks += 2;
        if (o_count !== 4'd1) begin errors++; $display("FAIL zero_count got=%0d want=1", o_count); end
        if (o_fl_data !== 5'd7) begin errors++; $display("FAIL zero_data got=%0d want=7", o_fl_data); end
        fl_full = 1'b0;
        #1;
        tick();
        checks += 2;
        if (o_count !== 4'd0) begin errors++; $display("FAIL zero_drain_count got=%0d want=0", o_count); end
        if (o_fl_data !== 5'd0) begin errors++; $display("FAIL zero_empty_data got=%0d want=0", o_fl_data); end
    endtask

    task automatic test_full_hold();
        fl_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = 2'b11; p0 = 5'(2 * i + 1); p1 = 5'(2 * i + 2);
            tick();
        end
        valid = 2'b11; p0 = 5'd7; p1 = 5'd0;
        tick();
        valid = 2'b11; p0 = 5'd8; p1 = 5'd9;
        #1;
        checks += 3;
        if (o_count !== 4'd7) begin errors++; $display("FAIL hold_count got=%0d want=7", o_count); end
        if (o_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got=%b want=0", o_ready); end
        if (o_fl_we !== 1'b0) begin errors++; $display("FAIL hold_we got=%b want=0", o_fl_we); end
        tick();
        tick();
        checks += 2;
        if (o_count !== 4'd7) begin errors++; $display("FAIL hold_ignored_count got=%0d want=7", o_count); end
        if (o_fl_data !== 5'd1) begin errors++; $display("FAIL hold_head got=%0d want=1", o_fl_data); end
        valid = 2'b00; fl_full = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            #1;
            checks += 3;
            if (o_fl_we !== m_we()) begin errors++; $display("FAIL hold_drain_we got=%b want=%b", o_fl_we, m_we()); end
            if (o_fl_data !== m_data()) begin errors++; $display("FAIL hold_drain_data got=%0d want=%0d", o_fl_data, m_data()); end
            if (o_count !== m_count()) begin errors++; $display("FAIL hold_drain_count got=%0d want=%0d", o_count, m_count()); end
            tick();
        end
        checks++;
        if (o_count !== 4'd0) begin errors++; $display("FAIL hold_drain_end got=%0d want=0", o_count); end
    endtask

    task automatic test_wrap();
        int unsigned seen[$];
        int unsigned next;
        int unsigned k;
        logic        acc;
        do_reset();
        next = 1;
        for (int c = 0; c < 400 && seen.size() < 24; c++) begin
            valid = 2'($urandom_range(0, 3));
            k = next;
            p0 = 5'($urandom_range(0, 31));
            p1 = 5'($urandom_range(0, 31));
            if (valid[0]) begin
                if (k <= 24) begin p0 = 5'(k); k++; end else valid[0] = 1'b0;
            end
            if (valid[1]) begin
                if (k <= 24) begin p1 = 5'(k); k++; end else valid[1] = 1'b0;
            end
            fl_full = 1'($urandom_range(0, 1));
            #1;
            checks += 4;
            if (o_ready !== m_ready()) begin errors++; $display("FAIL wrap_ready got=%b want=%b", o_ready, m_ready()); end
            if (o_fl_we !== m_we()) begin errors++; $display("FAIL wrap_we got=%b want=%b", o_fl_we, m_we()); end
            if (o_fl_data !== m_data()) begin errors++; $display("FAIL wrap_data got=%0d want=%0d", o_fl_data, m_data()); end
            if (o_count !== m_count()) begin errors++; $display("FAIL wrap_count got=%0d want=%0d", o_count, m_count()); end
            if (o_fl_we === 1'b1) seen.push_back(int'(o_fl_data));
            acc = m_ready();
            tick();
            if (acc) next = k;
        end
        valid = 2'b00;
        checks++;
        if (seen.size() != 24) begin
            errors++; $display("FAIL wrap_len got=%0d want=24", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 24; i++) begin
            checks++;
            if (seen[i] != i + 1) begin
                errors++; $display("FAIL wrap_order idx=%0d got=%0d want=%0d", i, seen[i], i + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fl_full = 1'b1;
        valid = 2'b11; p0 = 5'd11; p1 = 5'd12;
        tick();
        valid = 2'b11; p0 = 5'd13; p1 = 5'd14;
        tick();
        valid = 2'b00; fl_full = 1'b0;
        #1;
        checks++;
        if (o_count !== 4'd4) begin errors++; $display("FAIL areset_pre_count got=%0d want=4", o_count); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (o_fl_we !== 1'b0) begin errors++; $display("FAIL areset_we got=%b want=0", o_fl_we); end
        if (o_count !== 4'd0) begin errors++; $display("FAIL areset_count got=%0d want=0", o_count); end
        if (o_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b want=1", o_ready); end
        if (o_fl_data !== 5'd0) begin errors++; $display("FAIL areset_data got=%0d want=0", o_fl_data); end
        rst = 1'b0;
        q.delete();
        valid = 2'b01; p0 = 5'd3; p1 = 5'd0;
        tick();
        valid = 2'b00;
        #1;
        checks += 2;
        if (o_fl_data !== 5'd3) begin errors++; $display("FAIL areset_push_data got=%0d want=3", o_fl_data); end
        if (o_count !== 4'd1) begin errors++; $display("FAIL areset_push_count got=%0d want=1", o_count); end
        tick();
    endtask

    task automatic test_loopback();
        int unsigned fl[$];
        int unsigned sorted[$];
        logic        acc;
        do_reset();
        for (int i = 1; i <= 31; i++) fl.push_back(i);
        for (int c = 0; c < 1000; c++) begin
            fl_full = ($urandom_range(0, 3) == 0);
            p1 = 5'($urandom_range(0, 31));
            if (fl.size() != 0) begin
                valid = 2'b01; p0 = 5'(fl[0]);
            end else begin
                valid = 2'b00; p0 = '0;
            end
            #1;
            checks += 4;
            if (o_ready !== m_ready()) begin errors++; $display("FAIL loop_ready got=%b want=%b", o_ready, m_ready()); end
            if (o_fl_we !== m_we()) begin errors++; $display("FAIL loop_we got=%b want=%b", o_fl_we, m_we()); end
            if (o_fl_data !== m_data()) begin errors++; $display("FAIL loop_data got=%0d want=%0d", o_fl_data, m_data()); end
            if (o_count !== m_count()) begin errors++; $display("FAIL loop_count got=%0d want=%0d", o_count, m_count()); end
            acc = m_ready() && valid[0];
            if (o_fl_we === 1'b1) fl.push_back(int'(o_fl_data));
            tick();
            if (acc) void'(fl.pop_front());
        end
        valid = 2'b00; fl_full = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            #1;
            if (o_fl_we === 1'b1) fl.push_back(int'(o_fl_data));
            tick();
        end
        sorted = fl;
        sorted.sort();
        checks++;
        if (sorted.size() != 31) begin
            errors++; $display("FAIL loop_conserve_size got=%0d want=31", sorted.size());
        end
        for (int i = 0; i < sorted.size() && i < 31; i++) begin
            checks++;
            if (sorted[i] != i + 1) begin
                errors++; $display("FAIL loop_conserve idx=%0d got=%0d want=%0d", i, sorted[i], i + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid = 2'b00; p0 = '0; p1 = '0; fl_full = 1'b0;
        test_reset();
        test_pair();
        test_zero_filter();
        test_full_hold();
        test_wrap();
        test_async_reset();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
